// File: rtl/efi_coil_router.sv
`default_nettype none
// ============================================================================
// Module   : efi_coil_router
// Purpose  : N-channel ignition coil output stage with request routing,
//            dwell limiting, minimum off-time and spark event counting.
//            Optional macro: COIL_FAULT_LOCKOUT_EN (latch channel off on fault)
// Revision : 1.0  initial release
// ============================================================================
module efi_coil_router #(
    parameter int N_CH = 4,
    parameter int DW   = 16,
    parameter int CW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [N_CH-1:0] ch_en,
    input  logic [N_CH-1:0] req_in,
    input  logic [DW-1:0]   max_dwell,
    input  logic [DW-1:0]   min_off,
    input  logic            fault_clr,
    output logic [N_CH-1:0] coil_out,
    output logic [N_CH-1:0] fault,
    output logic            spark_pulse,
    output logic [CW-1:0]   spark_cnt
);

    localparam int c_HALF = N_CH / 2;

`ifdef COIL_FAULT_LOCKOUT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DWELL = 2'd1, S_OFF = 2'd2, S_LOCK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DWELL = 2'd1, S_OFF = 2'd2} state_t;
`endif

    if ((N_CH < 2) || ((N_CH % 2) != 0)) begin : g_bad_n_ch
        $error("efi_coil_router: N_CH must be even and >= 2");
    end

    logic [N_CH-1:0] w_route;
    logic [N_CH-1:0] w_r;
    logic [N_CH-1:0] w_norm_rel;
    logic [N_CH-1:0] w_forced;
    logic [CW-1:0]   w_rel_count;
    logic [DW-1:0]   w_off_lim;

    always_comb begin
        w_route = '0;
        case (mode)
            2'd0: w_route = req_in;
            2'd1: begin
                for (int i = 0; i < c_HALF; i++) begin
                    w_route[i]          = req_in[i] | req_in[i + c_HALF];
                    w_route[i + c_HALF] = req_in[i] | req_in[i + c_HALF];
                end
            end
            2'd2: w_route[0] = |req_in;
            default: w_route = '0;
        endcase
        w_r = w_route & ch_en & {N_CH{en}};
    end

    assign w_off_lim = (min_off == '0) ? DW'(1) : min_off;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t        r_state;
        logic [DW-1:0] r_cnt;
        logic          r_coil;
        logic          r_fault;
        logic          r_prev;
        logic          r_armed;
        logic          w_rise;
        logic          w_dwell_hit;
        logic          w_off_done;
`ifdef COIL_FAULT_LOCKOUT_EN
        logic          r_lock_pend;
`endif

        // r_armed is cleared by reset so a request held through reset must drop before it can dwell again
        assign w_rise      = w_r[i] & ~r_prev & r_armed;
        assign w_dwell_hit = (max_dwell != '0) &&
                             (({1'b0, r_cnt} + (DW+1)'(1)) >= {1'b0, max_dwell});
        assign w_off_done  = ({1'b0, r_cnt} + (DW+1)'(1)) >= {1'b0, w_off_lim};
        assign w_norm_rel[i] = (r_state == S_DWELL) & ~w_r[i];
        assign w_forced[i]   = (r_state == S_DWELL) & w_r[i] & w_dwell_hit;
        assign coil_out[i]   = r_coil;
        assign fault[i]      = r_fault;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state     <= S_IDLE;
                r_cnt       <= '0;
                r_coil      <= 1'b0;
                r_fault     <= 1'b0;
                r_prev      <= 1'b0;
                r_armed     <= 1'b0;
`ifdef COIL_FAULT_LOCKOUT_EN
                r_lock_pend <= 1'b0;
`endif
            end else begin
                r_prev  <= w_r[i];
                r_armed <= r_armed | ~w_r[i];
                if (w_forced[i]) begin
                    r_fault <= 1'b1;
                end else if (fault_clr) begin
                    r_fault <= 1'b0;
                end
                case (r_state)
                    S_IDLE: begin
                        r_coil <= 1'b0;
                        if (w_rise) begin
                            r_state <= S_DWELL;
                            r_cnt   <= '0;
                            r_coil  <= 1'b1;
                        end
                    end
                    S_DWELL: begin
                        if (w_norm_rel[i] || w_forced[i]) begin
                            r_state     <= S_OFF;
                            r_cnt       <= '0;
                            r_coil      <= 1'b0;
`ifdef COIL_FAULT_LOCKOUT_EN
                            r_lock_pend <= w_forced[i];
`endif
                        end else if (r_cnt != '1) begin
                            r_cnt <= r_cnt + DW'(1);
                        end
                    end
                    S_OFF: begin
                        r_coil <= 1'b0;
                        if (w_off_done) begin
                            r_cnt   <= '0;
`ifdef COIL_FAULT_LOCKOUT_EN
                            r_state <= r_lock_pend ? S_LOCK : S_IDLE;
`else
                            r_state <= S_IDLE;
`endif
                        end else begin
                            r_cnt <= r_cnt + DW'(1);
                        end
                    end
`ifdef COIL_FAULT_LOCKOUT_EN
                    S_LOCK: begin
                        r_coil <= 1'b0;
                        if (fault_clr) begin
                            r_state     <= S_IDLE;
                            r_lock_pend <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                        r_coil  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_rel_count = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_rel_count = w_rel_count + CW'(w_norm_rel[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spark_pulse <= 1'b0;
            spark_cnt   <= '0;
        end else begin
            spark_pulse <= |w_norm_rel;
            spark_cnt   <= spark_cnt + w_rel_count;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_efi_coil_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_efi_coil_router
// Purpose  : Directed self-checking bench for efi_coil_router with a
//            cycle-level behavioural model compared on every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_efi_coil_router;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic [N-1:0]  ch_en;
    logic [N-1:0]  req_in;
    logic [15:0]   max_dwell;
    logic [15:0]   min_off;
    logic          fault_clr;
    logic [N-1:0]  coil_out;
    logic [N-1:0]  fault;
    logic          spark_pulse;
    logic [15:0]   spark_cnt;

    efi_coil_router #(.N_CH(N), .DW(16), .CW(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .ch_en       (ch_en),
        .req_in      (req_in),
        .max_dwell   (max_dwell),
        .min_off     (min_off),
        .fault_clr   (fault_clr),
        .coil_out    (coil_out),
        .fault       (fault),
        .spark_pulse (spark_pulse),
        .spark_cnt   (spark_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit run   = 1'b0;
    int hi_cnt[N];
    int n_pulse = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Model: m_on = cycles the coil has been on (0 = off), m_off = cycles spent in the off window (-1 = none)
    int           m_on[N];
    int           m_off[N];
    bit           m_prev[N];
    bit           m_need_low[N];
    bit           m_pend[N];
    bit           m_lock[N];
    logic [N-1:0] e_fault;
    logic         e_pulse;
    logic [15:0]  e_cnt;

    always @(posedge clk or posedge reset) begin : model
        logic [N-1:0] r;
        int rel;
        int lim;
        bit forced;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_on[i] = 0; m_off[i] = -1; m_prev[i] = 0;
                m_need_low[i] = 1; m_pend[i] = 0; m_lock[i] = 0;
            end
            e_fault = '0; e_pulse = 1'b0; e_cnt = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case (mode)
                    2'd0: r[i] = req_in[i];
                    2'd1: r[i] = req_in[i] | req_in[(i + N/2) % N];
                    2'd2: r[i] = (i == 0) && (req_in != 0);
                    default: r[i] = 1'b0;
                endcase
                r[i] = r[i] & en & ch_en[i];
            end
            rel = 0;
            lim = (min_off == 0) ? 1 : int'(min_off);
            for (int i = 0; i < N; i++) begin
                forced = 0;
                if (m_on[i] > 0) begin
                    if (!r[i]) begin
                        rel++; m_on[i] = 0; m_off[i] = 0;
                    end else if (max_dwell != 0 && m_on[i] >= int'(max_dwell)) begin
                        forced = 1; m_on[i] = 0; m_off[i] = 0; m_pend[i] = 1;
                    end else begin
                        m_on[i]++;
                    end
                end else if (m_off[i] >= 0) begin
                    m_off[i]++;
                    if (m_off[i] >= lim) begin
                        m_off[i] = -1;
`ifdef COIL_FAULT_LOCKOUT_EN
                        m_lock[i] = m_pend[i];
`endif
                        m_pend[i] = 0;
                    end
                end else if (m_lock[i]) begin
                    if (fault_clr) m_lock[i] = 0;
                end else if (r[i] && !m_prev[i] && !m_need_low[i]) begin
                    m_on[i] = 1;
                end
                if (forced) e_fault[i] = 1'b1;
                else if (fault_clr) e_fault[i] = 1'b0;
                m_prev[i] = r[i];
                if (!r[i]) m_need_low[i] = 0;
            end
            e_pulse = (rel != 0);
            e_cnt   = e_cnt + 16'(rel);
        end
    end

    always @(negedge clk) begin : cmp
        logic [N-1:0] exp_c;
        if (run) begin
            for (int i = 0; i < N; i++) exp_c[i] = (m_on[i] > 0);
            check("coil_out", coil_out, exp_c);
            check("fault", fault, e_fault);
            check("spark_pulse", spark_pulse, e_pulse);
            check("spark_cnt", spark_cnt, e_cnt);
            for (int i = 0; i < N; i++) if (coil_out[i] === 1'b1) hi_cnt[i]++;
            if (spark_pulse === 1'b1) n_pulse++;
        end
    end

    initial begin
        for (int i = 0; i < N; i++) hi_cnt[i] = 0;
        reset = 1'b1; en = 1'b0; mode = 2'd0; ch_en = '1; req_in = '0;
        max_dwell = 16'd0; min_off = 16'd10; fault_clr = 1'b0;
        step(1);
        check("rst_coil", coil_out, 0);
        check("rst_fault", fault, 0);
        check("rst_pulse", spark_pulse, 0);
        check("rst_cnt", spark_cnt, 0);
        run = 1'b1;
        step(1);
        reset = 1'b0; en = 1'b1;
        step(2);

        // Sequential single channel
        req_in[2] = 1'b1; step(100); req_in[2] = 1'b0; step(15);
        check("t1_coil2_cycles", hi_cnt[2], 100);
        check("t1_others_low", hi_cnt[0] + hi_cnt[1] + hi_cnt[3], 0);
        check("t1_pulses", n_pulse, 1);
        check("t1_cnt", spark_cnt, 1);

        // Wasted spark pair 1/3
        mode = 2'd1;
        req_in[1] = 1'b1; step(50); req_in[1] = 1'b0; step(15);
        check("t2_coil1_cycles", hi_cnt[1], 50);
        check("t2_coil3_cycles", hi_cnt[3], 50);
        check("t2_pulses", n_pulse, 2);
        check("t2_cnt", spark_cnt, 3);

        // Over-dwell
        mode = 2'd0; max_dwell = 16'd20;
        req_in[0] = 1'b1; step(200);
        check("t3_coil0_cycles", hi_cnt[0], 20);
        check("t3_fault", fault, 4'b0001);
        check("t3_pulses", n_pulse, 2);
        req_in[0] = 1'b0; step(3);
        fault_clr = 1'b1; step(1); fault_clr = 1'b0;
        check("t3_fault_clr", fault, 0);
        req_in[0] = 1'b1; step(10); req_in[0] = 1'b0; step(15);
        check("t3_redwell_cycles", hi_cnt[0], 30);
        check("t3_cnt", spark_cnt, 4);

        // Minimum off-time
        max_dwell = 16'd0; min_off = 16'd30;
        req_in[0] = 1'b1; step(5); req_in[0] = 1'b0;
        step(10); req_in[0] = 1'b1; step(28);
        check("t4_ignored_edge", hi_cnt[0], 35);
        req_in[0] = 1'b0; step(2); req_in[0] = 1'b1; step(10); req_in[0] = 1'b0; step(35);
        check("t4_late_edge_cycles", hi_cnt[0], 45);
        check("t4_cnt", spark_cnt, 6);

        // Distributor
        mode = 2'd2; min_off = 16'd3;
        for (int k = 0; k < N; k++) begin
            req_in[k] = 1'b1; step(5); req_in[k] = 1'b0; step(6);
        end
        step(2);
        check("t5_coil0_cycles", hi_cnt[0], 65);
        check("t5_coil123_unchanged", hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 200);
        check("t5_cnt", spark_cnt, 10);

        // All-off mode, then enable gating mid-dwell
        mode = 2'd3; req_in[0] = 1'b1; step(5); req_in[0] = 1'b0; step(3);
        check("t6_mode3_off", hi_cnt[0], 65);
        mode = 2'd0; req_in[3] = 1'b1; step(5); en = 1'b0; step(1);
        check("t6_gate_coil", coil_out, 0);
        check("t6_gate_cnt", spark_cnt, 11);
        req_in[3] = 1'b0; step(1); en = 1'b1; step(12);

        // Asynchronous reset mid-dwell
        max_dwell = 16'd8; min_off = 16'd10;
        req_in[2] = 1'b1; step(12);
        check("t7_fault2", fault, 4'b0100);
        req_in[1] = 1'b1; step(5);
        check("t7_dwell1", coil_out, 4'b0010);
        reset = 1'b1; #1;
        check("t7_async_coil", coil_out, 0);
        check("t7_async_fault", fault, 0);
        check("t7_async_cnt", spark_cnt, 0);
        step(2); reset = 1'b0; step(10);
        check("t7_held_no_dwell", coil_out, 0);
        req_in = '0; step(12);
        req_in[1] = 1'b1; step(4);
        check("t7_fresh_edge", coil_out, 4'b0010);
        req_in[1] = 1'b0; step(12);
        check("t7_cnt", spark_cnt, 1);
        check("t7_fault_end", fault, 0);

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/efi_coil_router.md
Name: efi_coil_router

Overview:
- Parametrised N-channel ignition coil output stage, placed between the per-cylinder ign_driver instances and the ign_* pins.
- Replaces the fixed 4-channel distributor/individual output mux with three routing modes: sequential, wasted spark and distributor.
- Adds per-channel dwell-limit protection, minimum off-time enforcement, sticky fault flags, and a spark event counter that the SPI status registers can read.

Parameters:
N_CH, 4, number of coil channels; must be even and >= 2, otherwise elaboration error
DW, 16, width of dwell/off-time counters and limits
CW, 16, width of spark event counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  global output enable (synced & master enable)
mode  in  2  0=sequential, 1=wasted spark, 2=distributor, 3=all off
ch_en  in  N_CH  per-channel enable
req_in  in  N_CH  dwell requests from ign_driver instances (high = charge coil)
max_dwell  in  DW  max coil-on time in clk cycles; 0 = no limit
min_off  in  DW  minimum coil-off time after release, in clk cycles
fault_clr  in  1  clears all fault flags; single-cycle pulse, or level
coil_out  out  N_CH  coil drive outputs, registered
fault  out  N_CH  sticky over-dwell fault flags
spark_pulse  out  1  one-cycle pulse when any channel releases normally
spark_cnt  out  CW  running count of normal releases

Behaviour:
- Reset (async): coil_out=0, fault=0, spark_pulse=0, spark_cnt=0, all channel FSMs IDLE, request history=0.
- Routing (combinational, before the FSMs), routed request r[i]:
  - mode 0: r[i]=req_in[i].
  - mode 1: for i<N_CH/2, r[i]=r[i+N_CH/2]=req_in[i] | req_in[i+N_CH/2].
  - mode 2: r[0]=OR of all req_in; r[i>0]=0.
  - mode 3: all r=0.
  - Then r[i] &= en & ch_en[i].
- Edge detect: rise[i] = r[i] & ~r_prev[i]. r_prev is registered every cycle in all states.
- Per-channel FSM, states IDLE, DWELL, OFF (plus LOCK, see Optional Feature):
  - IDLE: coil low. On rise[i] -> DWELL, counter cleared.
  - DWELL: coil high, counter increments each cycle.
    - r[i]=0 -> OFF (normal release): spark event, counter cleared.
    - max_dwell!=0 and counter==max_dwell-1 while r[i]=1 -> OFF (forced release): fault[i] set, no spark event. Coil is therefore high for exactly max_dwell cycles.
  - OFF: coil low, counter increments. Leaves for IDLE after max(min_off,1) cycles. rise[i] during OFF is discarded, not queued.
  - If r[i] is still high on return to IDLE, there is no new dwell; a fresh rising edge is required.
- Gating: en=0 or ch_en[i]=0 while in DWELL drops r[i]. This counts as a normal release (spark event). This is deliberate: a coil must never be held on.
- Latency: coil_out rises 1 clk after req_in rises and falls 1 clk after req_in falls. spark_pulse is asserted in the same cycle as the falling coil_out.
- spark_cnt adds the number of channels that release normally in a cycle (wasted-spark pairs add 2). Wraps modulo 2^CW.
- Mode change mid-dwell: any channel whose routed request drops takes a normal release. Channels whose request stays high continue dwelling with no restart.
- fault: set on forced release, cleared by fault_clr. Set takes priority over fault_clr in the same cycle.
- max_dwell/min_off changing mid-count: the new value is compared on the next cycle. A counter already past a new, lower max_dwell forces release on the next cycle.

Optional Feature:
- Macro: COIL_FAULT_LOCKOUT_EN.
- Defined: a forced release goes DWELL -> OFF -> LOCK instead of IDLE. LOCK holds the coil low and ignores requests until fault_clr; the channel then goes LOCK -> IDLE next cycle. Other channels are unaffected.
- Undefined: no LOCK state; fault is a status flag only and the channel re-arms normally after OFF.

Test Plan:
- Sequential, N_CH=4, max_dwell=0, min_off=10. Pulse req_in[2] high for 100 cycles:
  - coil_out[2] high cycles 1..100 after the edge.
  - Single spark_pulse on release; spark_cnt=1; other coils stay low.
- Wasted spark: pulse req_in[1] for 50 cycles:
  - coil_out[1] and coil_out[3] high identically for 50 cycles.
  - One spark_pulse; spark_cnt += 2.
- Over-dwell: max_dwell=20, hold req_in[0] high for 200 cycles:
  - coil_out[0] high exactly 20 cycles; fault[0]=1; no spark_pulse.
  - No re-dwell until req_in[0] goes low then high again.
  - fault_clr -> fault[0]=0.
- Min-off: min_off=30. Release req_in[0], re-raise it after 10 cycles and hold:
  - Edge is ignored; coil stays low. A rising edge 40 cycles after release dwells normally.
- Distributor: mode=2, staggered pulses on req_in[0..3]:
  - All appear on coil_out[0]; coil_out[1..3]=0; spark_cnt += 4.
- Reset asserted mid-dwell on channel 1:
  - coil_out=0 immediately (async); counters and faults cleared.
  - A held request does not re-dwell after reset release until its next rising edge.
  - With COIL_FAULT_LOCKOUT_EN, a locked channel ignores edges until fault_clr.
